// File: rtl/iram_readback_fsm.sv
// IRAM readback engine: reads a contiguous block of instruction words from
// IRAM (1-cycle synchronous read) and streams them to a consumer over a
// valid/ready handshake. Status is published in a 32-bit flag register.
module iram_readback_fsm #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int ADDR_STRIDE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [DATA_W-1:0] rd_data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       flag_reg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] STRIDE_EXT = (ADDR_W+1)'(ADDR_STRIDE);
  localparam logic [ADDR_W:0] ONE_EXT    = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   remaining;
  logic              done_sticky;
  logic              wrapped;
  logic [ADDR_W:0]   next_addr_ext;

  // Next read address with its carry-out; the carry marks an address wrap.
  assign next_addr_ext = {1'b0, cur_addr} + STRIDE_EXT;

  // Status bits: busy, sticky completion, address wrap.
  assign flag_reg = {29'b0, wrapped, done_sticky, busy};

  // Single FSM with registered outputs; rd_en and done default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      rd_en       <= 1'b0;
      rd_addr_out <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_sticky <= 1'b0;
      wrapped     <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            done_sticky <= 1'b0;
            wrapped     <= 1'b0;
            if (word_count != '0) begin
              cur_addr    <= start_addr;
              remaining   <= word_count;
              rd_en       <= 1'b1;
              rd_addr_out <= start_addr;
              busy        <= 1'b1;
              state       <= RD;
            end else begin
              // Empty request completes immediately without touching IRAM.
              done        <= 1'b1;
              done_sticky <= 1'b1;
              state       <= DONE;
            end
          end
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          // IRAM data for the address issued in RD is present this cycle.
          data_out   <= rd_data_in;
          data_valid <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            remaining  <= remaining - ONE_EXT;
            if (remaining == ONE_EXT) begin
              busy        <= 1'b0;
              done        <= 1'b1;
              done_sticky <= 1'b1;
              state       <= DONE;
            end else begin
              cur_addr    <= next_addr_ext[ADDR_W-1:0];
              rd_addr_out <= next_addr_ext[ADDR_W-1:0];
              rd_en       <= 1'b1;
              if (next_addr_ext[ADDR_W]) begin
                wrapped <= 1'b1;
              end
              state <= RD;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iram_readback_fsm.sv
// Testbench for iram_readback_fsm: an IRAM model plus a transaction-level
// reference (expected address list, expected words, expected wrap flag).
module tb_iram_readback_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  start_addr;
  logic [9:0]  word_count;
  logic        rd_en;
  logic [8:0]  rd_addr_out;
  logic [31:0] rd_data_in;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        done;
  logic [31:0] flag_reg;

  logic [31:0] mem [0:511];
  int tests = 0;
  int failures = 0;

  iram_readback_fsm #(.ADDR_W(9), .DATA_W(32), .ADDR_STRIDE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .word_count(word_count), .rd_en(rd_en), .rd_addr_out(rd_addr_out),
    .rd_data_in(rd_data_in), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .busy(busy), .done(done), .flag_reg(flag_reg)
  );

  always #5 clk = ~clk;

  // IRAM model: one-cycle synchronous read.
  always @(posedge clk) begin
    if (rd_en) rd_data_in <= mem[rd_addr_out];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr_out, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_data_valid"}, data_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_flag"}, flag_reg, 0);
  endtask

  // mode 0: ready always high (latency checked); 1: random ready;
  // 2: ready held low for 5 cycles while the first word is valid.
  task automatic run_txn(input logic [8:0] sa, input int wc, input int mode, input bit inject);
    logic [8:0] exp_addr[$];
    int nrd = 0, nacc = 0, ndone = 0, first_dv = -1, done_idx = -1, stall_left = 5;
    int budget;
    bit wrap_exp;
    logic [63:0] flag_exp;
    for (int i = 0; i < wc; i++) exp_addr.push_back(9'((int'(sa) + 4 * i) % 512));
    wrap_exp = (wc > 0) && (int'(sa) + 4 * (wc - 1) >= 512);
    flag_exp = 64'({wrap_exp, 2'b10});
    budget = 20 * wc + 50;
    @(negedge clk);
    start = 1'b1; start_addr = sa; word_count = 10'(wc); data_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (inject) begin
        if (cyc == 4) begin
          start = 1'b1; start_addr = 9'h100; word_count = 10'd7;
        end else begin
          start = 1'b0;
        end
      end
      case (mode)
        0: data_ready = 1'b1;
        1: data_ready = 1'($urandom_range(0, 1));
        default: begin
          if (data_valid && stall_left > 0) begin
            data_ready = 1'b0;
            stall_left--;
          end else begin
            data_ready = 1'b1;
          end
        end
      endcase
      if (done_idx >= 0 && cyc == done_idx + 1) begin
        check("done_one_cycle", done, 0);
        check("flag_idle", flag_reg, flag_exp);
        break;
      end
      if (rd_en) begin
        if (nrd < wc) check("rd_addr", rd_addr_out, exp_addr[nrd]);
        check("rd_no_valid", data_valid, 0);
        check("busy_rd", busy, 1);
        check("flag_busy_rd", flag_reg[0], 1);
        nrd++;
      end
      if (data_valid) begin
        if (first_dv < 0) first_dv = cyc;
        if (nacc < wc) begin
          if (data_ready) check("data_out", data_out, mem[exp_addr[nacc]]);
          else check("held_data", data_out, mem[exp_addr[nacc]]);
        end
        if (data_ready) nacc++;
      end
      if (done) begin
        ndone++;
        done_idx = cyc;
        check("busy_in_done", busy, 0);
        check("flag_done", flag_reg, flag_exp);
      end
    end
    start = 1'b0;
    check("done_count", ndone, 1);
    check("read_count", nrd, wc);
    check("accept_count", nacc, wc);
    if (mode == 0) begin
      check("first_valid_latency", first_dv, (wc > 0) ? 2 : -1);
      check("done_latency", done_idx, 3 * wc);
    end
  endtask

  initial begin
    int accepted;
    rst = 1'b1; start = 1'b0; start_addr = '0; word_count = '0; data_ready = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[9'h010] = 32'hA1; mem[9'h014] = 32'hB2; mem[9'h018] = 32'hC3;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    run_txn(9'h010, 3, 0, 1'b0);   // basic
    run_txn(9'h010, 3, 2, 1'b0);   // backpressure
    run_txn(9'h1FC, 2, 0, 1'b0);   // wrap
    run_txn(9'h020, 0, 0, 1'b0);   // zero count
    run_txn(9'h040, 4, 0, 1'b1);   // ignored start

    // Reset while word 3 of 4 is waiting in OUT.
    @(negedge clk);
    start = 1'b1; start_addr = 9'h080; word_count = 10'd4; data_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    accepted = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (data_valid) begin
        if (accepted >= 2) begin
          data_ready = 1'b0;
          break;
        end
        accepted++;
      end
    end
    check("reset_pre_valid", data_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    data_ready = 1'b1;
    check_all_zero("mid_reset");
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      check("post_reset_no_rd", rd_en, 0);
    end
    run_txn(9'h0A0, 3, 0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      run_txn(9'($urandom_range(0, 511)), int'($urandom_range(1, 20)), 1, 1'b0);
    end

    run_txn(9'h000, 512, 0, 1'b0); // max count

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/iram_readback_fsm.md
Name: iram_readback_fsm

Overview:
Reads a contiguous block of instruction words back out of IRAM, starting from a given address, and streams them to a consumer over a valid/ready handshake. It is the read-side counterpart of the instruction loader: the loader writes IRAM, and this block dumps it for host readback and load verification. It drives the IRAM read port (1-cycle synchronous read latency) and publishes status in a 32-bit flag register.

Parameters:
ADDR_W, 9, IRAM address width
DATA_W, 32, instruction word width
ADDR_STRIDE, 4, address increment per word

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request pulse; sampled only in IDLE
start_addr  in  ADDR_W  first IRAM address to read
word_count  in  ADDR_W+1  number of words to read (0..512)
rd_en  out  1  IRAM read enable (registered)
rd_addr_out  out  ADDR_W  IRAM read address (registered)
rd_data_in  in  DATA_W  IRAM read data, valid the cycle after rd_en
data_out  out  DATA_W  streamed instruction word
data_valid  out  1  data_out valid
data_ready  in  1  consumer accepts data_out
busy  out  1  readback in progress
done  out  1  one-cycle completion pulse
flag_reg  out  32  status: [0]=busy, [1]=done sticky, [2]=address wrapped, [31:3]=0

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; rd_en=0, rd_addr_out=0, data_out=0, data_valid=0, busy=0, done=0, flag_reg=0. Applies mid-operation too. Remaining reads are abandoned, with no rd_en in the cycle after reset.
- States: IDLE, RD, CAP, OUT, DONE.
- IDLE: start=1 and word_count!=0 latches start_addr into cur_addr and word_count into remaining, clears flag_reg[1] and flag_reg[2], then goes to RD. start=1 with word_count=0 clears flag_reg[2:1] and goes directly to DONE with no reads. start=0 stays in IDLE.
- RD (1 cycle): rd_en=1, rd_addr_out=cur_addr, busy=1. Next state is CAP.
- CAP (1 cycle): rd_en=0. At the end of this cycle, rd_data_in is captured into data_out and data_valid is set. Next state is OUT.
- OUT: data_valid=1. data_out is held stable while data_ready=0, with no limit on stall length. On an edge with data_valid && data_ready:
  - data_valid clears and remaining decrements.
  - If the new remaining is 0, go to DONE.
  - Otherwise cur_addr = (cur_addr + ADDR_STRIDE) mod 2^ADDR_W and go to RD.
  - If that increment overflows past the top of the address space, set flag_reg[2].
- DONE (1 cycle): done=1, busy=0, flag_reg[1] set (sticky until the next accepted start). Next state is IDLE.
- busy=1 in RD, CAP and OUT only. flag_reg[0] mirrors busy.
- start asserted outside IDLE is ignored; start_addr and word_count are not re-sampled.
- Latency (data_ready=1): start is sampled at edge E0; rd_en is high E0..E1; data_valid is high E2..E3. Each word costs 3 cycles. With N words, done is high for the cycle after handshake N.
- data_out keeps its last value after transfer. Only data_valid qualifies it.
- rd_en is never asserted while data_valid=1, so at most one read is outstanding.

Test Plan:
- Basic: IRAM[0x010,0x014,0x018]=A1,B2,C3, start_addr=0x010, word_count=3, data_ready=1 → rd_addr_out 0x010, 0x014, 0x018 one rd_en cycle each; data_out A1, B2, C3 valid at E2, E5, E8; done pulses E9..E10; flag_reg=0x2 afterwards.
- Backpressure: same load, data_ready=0 for 5 cycles while the first word is valid → data_out=A1 held stable with data_valid=1; no rd_en during the stall; the sequence resumes after ready rises with no word lost or duplicated.
- Wrap: start_addr=0x1FC, word_count=2 → reads 0x1FC then 0x000; flag_reg[2]=1 after completion.
- Zero count / ignored start: word_count=0 → no rd_en, done pulses the cycle after start, flag_reg=0x2. A start pulse with different start_addr during an active 4-word readback → has no effect.
- Reset mid-operation: assert rst while in OUT after word 2 of 4 → next cycle all outputs 0, state IDLE, no further rd_en; a new start then works normally from its own start_addr.
- Max count: word_count=512, start_addr=0 → 512 words read, addresses stepping by 4 mod 512, done once at the end.
